// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a one-entry skid buffer, flush-to-bubble and sync reset.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_bubble_cnt
`endif
);

  logic              out_valid_r;
  logic [CTRL_W-1:0] out_ctrl_r;
  logic [DATA_W-1:0] out_data_r;
  logic              s_valid_r;
  logic [CTRL_W-1:0] s_ctrl_r;
  logic [DATA_W-1:0] s_data_r;

  logic              out_valid_nxt_s;
  logic [CTRL_W-1:0] out_ctrl_nxt_s;
  logic [DATA_W-1:0] out_data_nxt_s;
  logic              s_valid_nxt_s;
  logic [CTRL_W-1:0] s_ctrl_nxt_s;
  logic [DATA_W-1:0] s_data_nxt_s;
  logic              in_ready_s;
  logic              accept_s;

  // Readiness depends only on local state so out_ready never reaches in_ready combinationally.
  assign in_ready_s = ~s_valid_r & ~rst;
  assign accept_s   = in_valid & in_ready_s;

  // Next-state selection for the main and skid registers.
  always_comb begin
    out_valid_nxt_s = out_valid_r;
    out_ctrl_nxt_s  = out_ctrl_r;
    out_data_nxt_s  = out_data_r;
    s_valid_nxt_s   = s_valid_r;
    s_ctrl_nxt_s    = s_ctrl_r;
    s_data_nxt_s    = s_data_r;
    if (flush) begin
      out_valid_nxt_s = 1'b0;
      out_ctrl_nxt_s  = {CTRL_W{1'b0}};
      s_valid_nxt_s   = 1'b0;
    end else if (s_valid_r) begin
      if (out_ready) begin
        out_valid_nxt_s = 1'b1;
        out_ctrl_nxt_s  = s_ctrl_r;
        out_data_nxt_s  = s_data_r;
        s_valid_nxt_s   = 1'b0;
      end else begin
        s_valid_nxt_s   = 1'b1;
      end
    end else if (accept_s && (!out_valid_r || out_ready)) begin
      out_valid_nxt_s = 1'b1;
      out_ctrl_nxt_s  = in_ctrl;
      out_data_nxt_s  = in_data;
    end else if (accept_s) begin
      // Downstream stalled with M occupied: park the new item in the skid slot.
      s_valid_nxt_s   = 1'b1;
      s_ctrl_nxt_s    = in_ctrl;
      s_data_nxt_s    = in_data;
    end else if (out_ready) begin
      out_valid_nxt_s = 1'b0;
      out_ctrl_nxt_s  = {CTRL_W{1'b0}};
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_ctrl_r  <= {CTRL_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      s_valid_r   <= 1'b0;
      s_ctrl_r    <= {CTRL_W{1'b0}};
      s_data_r    <= {DATA_W{1'b0}};
    end else begin
      out_valid_r <= out_valid_nxt_s;
      out_ctrl_r  <= out_ctrl_nxt_s;
      out_data_r  <= out_data_nxt_s;
      s_valid_r   <= s_valid_nxt_s;
      s_ctrl_r    <= s_ctrl_nxt_s;
      s_data_r    <= s_data_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_ctrl  = out_ctrl_r;
  assign out_data  = out_data_r;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Saturating perf counters; only reset clears them, flush bubbles are counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_valid_r && !out_ready) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!out_valid_r) begin
        bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_r;
  assign perf_bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: scoreboard queue checks order/content, directed checks cover
// reset, stream, bubble, stall, flush, mid-operation reset and (with PIPE_STAGE_PERF_EN) the counters.
module tb_pipe_stage_reg;
  localparam int CW = 16;
  localparam int DW = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_bubble_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [CW+DW-1:0] sb[$];
  logic [CW+DW-1:0] exp_item;
  logic [DW-1:0]    held_data;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    for (int k = 0; k < 5; k++) in_data[k*32 +: 32] = $urandom;
  endtask

  // One clock: scoreboard bookkeeping at the falling edge, then return 1 unit after the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b0) chk("inv_ctrl_zero", out_ctrl, 0);
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL sb_unexpected observed_ctrl=%0h expected=none", out_ctrl);
        end
        if (sb.size() != 0) begin
          exp_item = sb.pop_front();
          chk("sb_ctrl", out_ctrl, exp_item[CW+DW-1:DW]);
          chk("sb_data", out_data, exp_item[DW-1:0]);
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 16'h1234);
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    drive(1'b0, 16'h0000);
    #1;
    chk("rst_rel_in_ready", in_ready, 1);

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i));
      cyc();
      chk("stream_valid", out_valid, 1);
      chk("stream_ctrl", out_ctrl, i);
      chk("stream_in_ready", in_ready, 1);
    end
    drive(1'b0, 16'hFFFF);
    cyc();
    chk("bubble_valid", out_valid, 0);
    chk("bubble_ctrl", out_ctrl, 16'h0000);
    drive(1'b1, 16'h0009);
    cyc();
    chk("post_bubble_ctrl", out_ctrl, 16'h0009);
    drive(1'b0, 16'h0000);
    cyc();

    // Stall with skid fill
    out_ready = 1'b0;
    drive(1'b1, 16'h00A1);
    cyc();
    chk("stall_a_valid", out_valid, 1);
    chk("stall_a_ctrl", out_ctrl, 16'h00A1);
    drive(1'b1, 16'h00B2);
    cyc();
    chk("stall_m_ctrl", out_ctrl, 16'h00A1);
    chk("stall_in_ready0", in_ready, 0);
    drive(1'b1, 16'h00C3);
    cyc();
    chk("stall_hold_ctrl", out_ctrl, 16'h00A1);
    chk("stall_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    cyc();
    chk("drain_b_ctrl", out_ctrl, 16'h00B2);
    chk("drain_in_ready1", in_ready, 1);
    cyc();
    chk("drain_c_ctrl", out_ctrl, 16'h00C3);
    drive(1'b0, 16'h0000);
    cyc();
    chk("drain_idle", out_valid, 0);

    // Flush with skid full and a new item presented
    out_ready = 1'b0;
    drive(1'b1, 16'h0AAA);
    held_data = in_data;
    cyc();
    drive(1'b1, 16'h0BBB);
    cyc();
    chk("flush_pre_ready", in_ready, 0);
    drive(1'b1, 16'h0DDD);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 16'h0000);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_data_held", out_data, held_data);
    out_ready = 1'b1;
    cyc();
    chk("flush_no_emit1", out_valid, 0);
    cyc();
    chk("flush_no_emit2", out_valid, 0);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    drive(1'b1, 16'h0111);
    cyc();
    drive(1'b1, 16'h0222);
    cyc();
    drive(1'b0, 16'h0000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cyc();
    chk("midrst_no_emit", out_valid, 0);

`ifdef PIPE_STAGE_PERF_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'h0F0F);
    cyc();
    drive(1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) cyc();
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("perf_stall", perf_stall_cnt, 5);
    chk("perf_bubble", perf_bubble_cnt, 3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("perf_stall_flush", perf_stall_cnt, 5);
    chk("perf_bubble_flush", perf_bubble_cnt, 4);
`endif

    cyc();
    chk("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
